// File: rtl/approx_mult_arbiter.sv
// approx_mult_arbiter
//   Round-robin front end that shares one external combinational approximate
//   6x6 multiplier among NUM_REQ requesters. A granted operand pair is
//   registered onto the multiplier inputs (stage S1); one cycle later the
//   product is captured together with the requester index (stage S2) and
//   offered on a single response channel with back-pressure.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_req_valid  per-requester operand valid
//   i_req_a/b    packed operands, requester i at [6i+5:6i]
//   o_req_ready  one-hot grant/accept
//   o_mult_a/b   registered operands driven to the multiplier
//   i_mult_p     combinational product returned by the multiplier
//   o_rsp_valid  response valid
//   i_rsp_ready  response consumer ready
//   o_rsp_p      product
//   o_rsp_id     index of the requester that issued the operation
//   o_busy       either pipeline stage holds an operation
//   o_ops_done   saturating count of completed responses
module approx_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [6*NUM_REQ-1:0] i_req_a,
    input  logic [6*NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [5:0]           o_mult_a,
    output logic [5:0]           o_mult_b,
    input  logic [11:0]          i_mult_p,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [11:0]          o_rsp_p,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_ops_done
);

    logic              r_s1Valid;
    logic [5:0]        r_multA;
    logic [5:0]        r_multB;
    logic [ID_W-1:0]   r_s1Id;
    logic              r_rspValid;
    logic [11:0]       r_rspP;
    logic [ID_W-1:0]   r_rspId;
    logic [ID_W-1:0]   r_ptr;
    logic [CNT_W-1:0]  r_opsDone;

    logic              w_s2Adv;
    logic              w_s1Adv;
    logic              w_accept;
    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [5:0]        w_selA;
    logic [5:0]        w_selB;
    logic              w_xfer;
    logic [ID_W-1:0]   w_ptrNext;

    // Pipeline advance conditions. Acceptance is also blocked while reset is
    // asserted so a requester never sees a handshake that reset discards.
    assign w_s2Adv  = !r_rspValid || i_rsp_ready;
    assign w_s1Adv  = r_s1Valid && w_s2Adv;
    assign w_accept = !i_rst && (!r_s1Valid || w_s2Adv);
    assign w_xfer   = w_found && w_accept;

    // Round-robin scan without a modulo: first look for a valid requester at
    // or above the pointer, and only if none exists take the lowest valid one
    // below it, which is exactly the wrap-around order.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_selA   = '0;
        w_selB   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (ID_W'(i) >= r_ptr)) begin
                w_found  = 1'b1;
                w_winner = ID_W'(i);
                w_selA   = i_req_a[6*i +: 6];
                w_selB   = i_req_b[6*i +: 6];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(i);
                w_selA   = i_req_a[6*i +: 6];
                w_selB   = i_req_b[6*i +: 6];
            end
        end
    end

    // One-hot ready: only the winner sees the accept condition.
    always_comb begin
        o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_req_ready[i] = w_found && (w_winner == ID_W'(i)) && w_accept;
        end
    end

    // Pointer moves just past the winner, wrapping at NUM_REQ (which need not
    // be a power of two).
    assign w_ptrNext = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + ID_W'(1);

    // Both pipeline stages, the round-robin pointer and the completion
    // counter. S1 may reload in the same cycle it moves into S2, which keeps
    // one operation per cycle flowing while the consumer is ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1Valid  <= 1'b0;
            r_multA    <= '0;
            r_multB    <= '0;
            r_s1Id     <= '0;
            r_rspValid <= 1'b0;
            r_rspP     <= '0;
            r_rspId    <= '0;
            r_ptr      <= '0;
            r_opsDone  <= '0;
        end else begin
            if (w_xfer) begin
                r_s1Valid <= 1'b1;
                r_multA   <= w_selA;
                r_multB   <= w_selB;
                r_s1Id    <= w_winner;
                r_ptr     <= w_ptrNext;
            end else if (w_s1Adv) begin
                r_s1Valid <= 1'b0;
            end

            if (w_s1Adv) begin
                r_rspValid <= 1'b1;
                r_rspP     <= i_mult_p;
                r_rspId    <= r_s1Id;
            end else if (w_s2Adv) begin
                r_rspValid <= 1'b0;
            end

            if (r_rspValid && i_rsp_ready && (r_opsDone != {CNT_W{1'b1}})) begin
                r_opsDone <= r_opsDone + CNT_W'(1);
            end
        end
    end

    assign o_mult_a    = r_multA;
    assign o_mult_b    = r_multB;
    assign o_rsp_valid = r_rspValid;
    assign o_rsp_p     = r_rspP;
    assign o_rsp_id    = r_rspId;
    assign o_busy      = r_s1Valid || r_rspValid;
    assign o_ops_done  = r_opsDone;

endmodule

// File: tb/tb_approx_mult_arbiter.sv
// tb_approx_mult_arbiter
//   Bench for approx_mult_arbiter. Requesters are modelled as operand queues
//   that hold valid until accepted; a stand-in approximate multiplier closes
//   the loop. A reference model of the scheduling rules is compared against
//   the DUT every cycle, and directed scenarios add literal expectations.
//   A second instance with a 4-bit counter exercises saturation.
module tb_approx_mult_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reqValid;
    logic [23:0] reqA;
    logic [23:0] reqB;
    logic        rspReady;

    logic [3:0]  reqReady;
    logic [5:0]  multA;
    logic [5:0]  multB;
    logic [11:0] multP;
    logic        rspValid;
    logic [11:0] rspP;
    logic [1:0]  rspId;
    logic        busy;
    logic [15:0] opsDone;

    logic [3:0]  reqReady2;
    logic [5:0]  multA2;
    logic [5:0]  multB2;
    logic [11:0] multP2;
    logic        rspValid2;
    logic [11:0] rspP2;
    logic [1:0]  rspId2;
    logic        busy2;
    logic [3:0]  opsDone2;

    int checks = 0;
    int fails  = 0;

    logic [5:0] qa [4][64];
    logic [5:0] qb [4][64];
    int qHead [4] = '{0, 0, 0, 0};
    int qTail [4] = '{0, 0, 0, 0};

    bit rstCmd      = 1'b1;
    bit rspReadyCmd = 1'b1;
    bit checkEn     = 1'b0;

    int          grantLog [$];
    int          rspIdLog [$];
    logic [11:0] rspPLog  [$];

    bit          mS1V;
    bit          mS2V;
    logic [5:0]  mA;
    logic [5:0]  mB;
    int          mS1Id;
    logic [11:0] mP;
    int          mId;
    int          mPtr;
    int          mCnt;

    always #5 clk = ~clk;

    // Stand-in approximate multiplier: exact product with the LSB forced high.
    function automatic logic [11:0] approxMul(input logic [5:0] a, input logic [5:0] b);
        return (12'(a) * 12'(b)) | 12'h001;
    endfunction

    assign multP  = approxMul(multA, multB);
    assign multP2 = approxMul(multA2, multB2);

    approx_mult_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_a(reqA), .i_req_b(reqB),
        .o_req_ready(reqReady), .o_mult_a(multA), .o_mult_b(multB), .i_mult_p(multP),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_p(rspP), .o_rsp_id(rspId),
        .o_busy(busy), .o_ops_done(opsDone)
    );

    approx_mult_arbiter #(.NUM_REQ(4), .CNT_W(4)) dutSat (
        .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_a(reqA), .i_req_b(reqB),
        .o_req_ready(reqReady2), .o_mult_a(multA2), .o_mult_b(multB2), .i_mult_p(multP2),
        .o_rsp_valid(rspValid2), .i_rsp_ready(rspReady), .o_rsp_p(rspP2), .o_rsp_id(rspId2),
        .o_busy(busy2), .o_ops_done(opsDone2)
    );

    // Single comparison point shared by the model checker and the scenarios.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Queue one operand pair for a requester.
    task automatic applyStimulus(input int id, input logic [5:0] a, input logic [5:0] b);
        qa[id][qTail[id]] = a;
        qb[id][qTail[id]] = b;
        qTail[id]++;
    endtask

    function automatic int logAt(input int k);
        return (k < grantLog.size()) ? grantLog[k] : -1;
    endfunction

    function automatic int rspIdAt(input int k);
        return (k < rspIdLog.size()) ? rspIdLog[k] : -1;
    endfunction

    function automatic int rspPAt(input int k);
        return (k < rspPLog.size()) ? int'(rspPLog[k]) : -1;
    endfunction

    // Wait until every queue is drained and the model pipeline is empty.
    task automatic waitIdle(input int maxCycles);
        int  n;
        bit  idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
            idle = !mS1V && !mS2V;
            for (int i = 0; i < NREQ; i++) begin
                if (qHead[i] != qTail[i]) idle = 1'b0;
            end
        end
        if (!idle) begin
            checks++;
            fails++;
            $display("[TB] FAIL idle_timeout: actual=busy expected=idle within %0d cycles", maxCycles);
        end
    endtask

    // Input driver: everything changes on the falling edge only.
    initial begin
        rst      = 1'b1;
        rspReady = 1'b1;
        reqValid = '0;
        reqA     = '0;
        reqB     = '0;
        forever begin
            @(negedge clk);
            rst      = rstCmd;
            rspReady = rspReadyCmd;
            for (int i = 0; i < NREQ; i++) begin
                if (qHead[i] < qTail[i]) begin
                    reqValid[i]     = 1'b1;
                    reqA[6*i +: 6]  = qa[i][qHead[i]];
                    reqB[6*i +: 6]  = qb[i][qHead[i]];
                end else begin
                    reqValid[i] = 1'b0;
                end
            end
        end
    end

    // Reference model and per-cycle compare, sampled mid low phase.
    initial begin : checkProc
        int         win;
        bit         found;
        bit         accept;
        bit         s2adv;
        bit         s1adv;
        bit         nS1V;
        bit         nS2V;
        logic [3:0] expReady;
        mS1V = 0; mS2V = 0; mA = '0; mB = '0; mS1Id = 0;
        mP = '0; mId = 0; mPtr = 0; mCnt = 0;
        forever begin
            @(negedge clk);
            #2;
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && reqValid[(mPtr + k) % NREQ]) begin
                    found = 1'b1;
                    win   = (mPtr + k) % NREQ;
                end
            end
            accept   = !rst && (!mS1V || !mS2V || rspReady);
            expReady = (found && accept) ? 4'(1 << win) : 4'b0000;

            if (checkEn) begin
                checkOutput("req_ready", 32'(reqReady), 32'(expReady));
                checkOutput("mult_a", 32'(multA), 32'(mA));
                checkOutput("mult_b", 32'(multB), 32'(mB));
                checkOutput("rsp_valid", 32'(rspValid), 32'(mS2V));
                checkOutput("rsp_p", 32'(rspP), 32'(mP));
                checkOutput("rsp_id", 32'(rspId), 32'(mId));
                checkOutput("busy", 32'(busy), 32'(mS1V || mS2V));
                checkOutput("ops_done", 32'(opsDone), 32'(mCnt));
                checkOutput("ops_done_sat", 32'(opsDone2), 32'((mCnt > 15) ? 15 : mCnt));
            end

            for (int i = 0; i < NREQ; i++) begin
                if (reqValid[i] && reqReady[i]) begin
                    grantLog.push_back(i);
                    qHead[i]++;
                end
            end
            if (rspValid && rspReady) begin
                rspIdLog.push_back(int'(rspId));
                rspPLog.push_back(rspP);
            end

            if (rst) begin
                mS1V = 0; mS2V = 0; mA = '0; mB = '0; mS1Id = 0;
                mP = '0; mId = 0; mPtr = 0; mCnt = 0;
            end else begin
                if (mS2V && rspReady && mCnt < 65535) mCnt++;
                s2adv = !mS2V || rspReady;
                s1adv = mS1V && s2adv;
                if (s1adv) begin
                    mP  = approxMul(mA, mB);
                    mId = mS1Id;
                end
                nS2V = s1adv ? 1'b1 : (s2adv ? 1'b0 : mS2V);
                if (found && accept) begin
                    mA    = reqA[6*win +: 6];
                    mB    = reqB[6*win +: 6];
                    mS1Id = win;
                    mPtr  = (win + 1) % NREQ;
                    nS1V  = 1'b1;
                end else begin
                    nS1V = s1adv ? 1'b0 : mS1V;
                end
                mS1V = nS1V;
                mS2V = nS2V;
            end
        end
    end

    // Directed scenarios.
    initial begin
        int base;
        int rBase;
        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b1;
        checkOutput("reset_ops_done", 32'(opsDone), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset_mult_a", 32'(multA), 32'd0);
        rstCmd = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] fairness: all requesters valid");
        base  = grantLog.size();
        rBase = rspIdLog.size();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                applyStimulus(i, 6'((i*13 + j*7 + 5) % 64), 6'((i*5 + j*11 + 9) % 64));
            end
        end
        waitIdle(40);
        for (int k = 0; k < 8; k++) begin
            checkOutput("fair_grant", 32'(logAt(base + k)), 32'(k % 4));
            checkOutput("fair_rsp_id", 32'(rspIdAt(rBase + k)), 32'(k % 4));
        end
        checkOutput("fair_first_p", 32'(rspPAt(rBase)), 32'd45);

        $display("[TB] single op: requester 2, 63x63");
        base  = grantLog.size();
        rBase = rspIdLog.size();
        applyStimulus(2, 6'd63, 6'd63);
        waitIdle(20);
        checkOutput("single_grant", 32'(logAt(base)), 32'd2);
        checkOutput("single_rsp_id", 32'(rspIdAt(rBase)), 32'd2);
        checkOutput("single_rsp_p", 32'(rspPAt(rBase)), 32'd3969);
        checkOutput("single_ops_done", 32'(opsDone), 32'd9);

        $display("[TB] back-pressure on requester 0 stream");
        rBase = rspIdLog.size();
        for (int k = 0; k < 4; k++) applyStimulus(0, 6'(k + 1), 6'(k + 2));
        repeat (2) @(posedge clk);
        #1;
        rspReadyCmd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_stall_valid", 32'(rspValid), 32'd1);
        checkOutput("bp_stall_busy", 32'(busy), 32'd1);
        rspReadyCmd = 1'b1;
        waitIdle(30);
        checkOutput("bp_rsp_count", 32'(rspIdLog.size() - rBase), 32'd4);
        checkOutput("bp_ops_done", 32'(opsDone), 32'd13);
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_rsp_p", 32'(rspPAt(rBase + k)), 32'(approxMul(6'(k + 1), 6'(k + 2))));
        end
        checkOutput("bp_first_p", 32'(rspPAt(rBase)), 32'd3);

        $display("[TB] pointer skip: requesters 1 and 3");
        applyStimulus(1, 6'd7, 6'd3);
        waitIdle(20);
        base = grantLog.size();
        applyStimulus(1, 6'd12, 6'd12);
        applyStimulus(3, 6'd33, 6'd2);
        applyStimulus(3, 6'd40, 6'd50);
        waitIdle(30);
        checkOutput("skip_grant0", 32'(logAt(base)), 32'd3);
        checkOutput("skip_grant1", 32'(logAt(base + 1)), 32'd1);
        checkOutput("skip_grant2", 32'(logAt(base + 2)), 32'd3);

        $display("[TB] reset with both stages occupied");
        rspReadyCmd = 1'b0;
        applyStimulus(0, 6'd21, 6'd22);
        applyStimulus(0, 6'd23, 6'd24);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_pre_valid", 32'(rspValid), 32'd1);
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        rBase  = rspIdLog.size();
        rstCmd = 1'b1;
        @(posedge clk);
        #1;
        rstCmd      = 1'b0;
        rspReadyCmd = 1'b1;
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ops_done", 32'(opsDone), 32'd0);
        checkOutput("rst_ops_done_sat", 32'(opsDone2), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_no_rsp", 32'(rspIdLog.size() - rBase), 32'd0);

        $display("[TB] saturation: 20 ops");
        base = grantLog.size();
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                applyStimulus(i, 6'(i + j), 6'(60 - i - j));
            end
        end
        waitIdle(100);
        checkOutput("sat_first_grant", 32'(logAt(base)), 32'd0);
        checkOutput("sat_ops_done", 32'(opsDone), 32'd20);
        checkOutput("sat_ops_done_4b", 32'(opsDone2), 32'd15);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
